// File: rtl/viterbi_param_if.sv
// viterbi_param_if: soft-symbol input and decoded-bit output bundle of the Viterbi decoder.
interface viterbi_param_if #(
  parameter int unsigned SOFT_W = 8,
  parameter int unsigned SM_W   = 20
);
  logic [SOFT_W-1:0] soft_inp;
  logic              valid_in_vit;
  logic              erase_in;
  logic              ready_in;
  logic              vit_desc;
  logic              valid_out_vit;
  logic              normalization;
  logic [SM_W-1:0]   sm_0_debug;

  // Upstream demodulator side.
  modport master (
    output soft_inp, valid_in_vit, erase_in,
    input  ready_in, vit_desc, valid_out_vit, normalization, sm_0_debug
  );

  // Decoder side.
  modport slave (
    input  soft_inp, valid_in_vit, erase_in,
    output ready_in, vit_desc, valid_out_vit, normalization, sm_0_debug
  );
endinterface

// File: rtl/viterbi_param.sv
// viterbi_param: parametrised hard-output Viterbi decoder (rate 1/2, soft input,
// erasure support, register-exchange survivors, bit-clear metric normalisation).
module viterbi_param #(
  parameter int unsigned K      = 7,
  parameter int unsigned POLY_A = 'o171,
  parameter int unsigned POLY_B = 'o133,
  parameter int unsigned SOFT_W = 8,
  parameter int unsigned SM_W   = 20,
  parameter int unsigned TB_LEN = 64
) (
  input  logic           clk,
  input  logic           sys_rst,
  input  logic           vit_clr,
  viterbi_param_if.slave vif
);
  localparam int unsigned NS     = 1 << (K - 1);
  localparam int unsigned SW     = K - 1;
  localparam int unsigned BM_W   = SOFT_W + 1;
  localparam int unsigned WARM_W = $clog2(TB_LEN + 1);

  localparam logic [K-1:0]      PA       = K'(POLY_A);
  localparam logic [K-1:0]      PB       = K'(POLY_B);
  localparam logic [SM_W-1:0]   PM_INIT  = SM_W'(1) << (SOFT_W + 2);
  localparam logic [SM_W-1:0]   NORM_BIT = SM_W'(1) << (SM_W - 2);
  localparam logic [SOFT_W-1:0] OFS      = SOFT_W'(1) << (SOFT_W - 1);
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(TB_LEN);

  typedef enum logic {PH_G1 = 1'b0, PH_G2 = 1'b1} phase_t;

  phase_t              r_phase;
  phase_t              w_phase_nxt;
  logic                w_clr;
  logic                w_accept;
  logic                w_step;

  logic [SOFT_W-1:0]   r_g1_soft;
  logic                r_g1_erase;

  logic [SM_W-1:0]     r_pm       [NS];
  logic [TB_LEN-1:0]   r_surv     [NS];
  logic [WARM_W-1:0]   r_warm;

  logic                r_desc;
  logic                r_vout;
  logic                r_norm;
  logic [SM_W-1:0]     r_sm0;

  logic [SOFT_W-1:0]   w_o1;
  logic [SOFT_W-1:0]   w_o2;
  logic [SOFT_W-1:0]   w_c1_0;
  logic [SOFT_W-1:0]   w_c1_1;
  logic [SOFT_W-1:0]   w_c2_0;
  logic [SOFT_W-1:0]   w_c2_1;
  logic [BM_W-1:0]     w_bm       [4];

  logic [SM_W-1:0]     w_m0       [NS];
  logic [SM_W-1:0]     w_m1       [NS];
  logic [SM_W-1:0]     w_new_pm   [NS];
  logic [SM_W-1:0]     w_pm_upd   [NS];
  logic [TB_LEN-1:0]   w_win_surv [NS];
  logic [TB_LEN-1:0]   w_new_surv [NS];
  logic [NS-1:0]       w_sel1;
  logic [NS-1:0]       w_ge;
  logic                w_norm;

  assign w_clr        = sys_rst || vit_clr;
  assign vif.ready_in = !sys_rst && !vit_clr;
  assign w_accept     = vif.valid_in_vit && vif.ready_in;

  // Symbol phase register: G1 or G2 expected next.
  always_ff @(posedge clk) begin
    if (w_clr) r_phase <= PH_G1;
    else       r_phase <= w_phase_nxt;
  end

  // Phase next-state; an accepted G2 launches one trellis step.
  always_comb begin
    w_phase_nxt = r_phase;
    w_step      = 1'b0;
    if (w_accept) begin
      case (r_phase)
        PH_G1: w_phase_nxt = PH_G2;
        PH_G2: begin
          w_phase_nxt = PH_G1;
          w_step      = 1'b1;
        end
        default: w_phase_nxt = PH_G1;
      endcase
    end
  end

  // Hold the G1 symbol and its erasure flag until the G2 arrives.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_g1_soft  <= '0;
      r_g1_erase <= 1'b0;
    end else if (w_accept && (r_phase == PH_G1)) begin
      r_g1_soft  <= vif.soft_inp;
      r_g1_erase <= vif.erase_in;
    end
  end

  // Branch costs: offset-binary soft value for a 0, its complement for a 1, zero if erased.
  always_comb begin
    w_o1   = r_g1_soft ^ OFS;
    w_o2   = vif.soft_inp ^ OFS;
    w_c1_0 = r_g1_erase   ? '0 : w_o1;
    w_c1_1 = r_g1_erase   ? '0 : ~w_o1;
    w_c2_0 = vif.erase_in ? '0 : w_o2;
    w_c2_1 = vif.erase_in ? '0 : ~w_o2;
    w_bm[0] = BM_W'(w_c1_0) + BM_W'(w_c2_0);
    w_bm[1] = BM_W'(w_c1_0) + BM_W'(w_c2_1);
    w_bm[2] = BM_W'(w_c1_1) + BM_W'(w_c2_0);
    w_bm[3] = BM_W'(w_c1_1) + BM_W'(w_c2_1);
  end

  // Add-compare-select per next state; expected symbols are elaboration constants.
  for (genvar n = 0; n < NS; n++) begin : g_acs
    localparam int unsigned  P0I   = (n * 2) % NS;
    localparam logic [SW-1:0] P0   = SW'(P0I);
    localparam logic [SW-1:0] P1   = SW'(P0I + 1);
    localparam logic          U    = 1'(n >> (K - 2));
    localparam logic [K-1:0]  WRD0 = {U, P0};
    localparam logic [K-1:0]  WRD1 = {U, P1};
    localparam logic [1:0]    E0   = {^(PA & WRD0), ^(PB & WRD0)};
    localparam logic [1:0]    E1   = {^(PA & WRD1), ^(PB & WRD1)};

    assign w_m0[n]       = r_pm[P0] + SM_W'(w_bm[E0]);
    assign w_m1[n]       = r_pm[P1] + SM_W'(w_bm[E1]);
    assign w_sel1[n]     = w_m1[n] < w_m0[n];
    assign w_new_pm[n]   = w_sel1[n] ? w_m1[n] : w_m0[n];
    assign w_win_surv[n] = w_sel1[n] ? r_surv[P1] : r_surv[P0];
    assign w_new_surv[n] = (w_win_surv[n] << 1) | TB_LEN'(U);
    assign w_ge[n]       = w_new_pm[n][SM_W-2];
    assign w_pm_upd[n]   = w_norm ? (w_new_pm[n] & ~NORM_BIT) : w_new_pm[n];
  end

  // Metrics stay below 2^(SM_W-1), so bit SM_W-2 set everywhere means all are over threshold.
  assign w_norm = &w_ge;

  // Path metrics and register-exchange survivors.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      for (int unsigned i = 0; i < NS; i++) begin
        r_pm[i]   <= (i == 0) ? '0 : PM_INIT;
        r_surv[i] <= '0;
      end
    end else if (w_step) begin
      for (int unsigned i = 0; i < NS; i++) begin
        r_pm[i]   <= w_pm_upd[i];
        r_surv[i] <= w_new_surv[i];
      end
    end
  end

  // Warm-up counter and registered decoder outputs.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_warm <= '0;
      r_desc <= 1'b0;
      r_vout <= 1'b0;
      r_norm <= 1'b0;
      r_sm0  <= '0;
    end else begin
      r_vout <= 1'b0;
      r_norm <= 1'b0;
      if (w_step) begin
        r_desc <= w_new_surv[0][TB_LEN-1];
        r_vout <= (r_warm == WARM_MAX);
        r_norm <= w_norm;
        r_sm0  <= w_pm_upd[0];
        if (r_warm != WARM_MAX) r_warm <= r_warm + WARM_W'(1);
      end
    end
  end

  assign vif.vit_desc      = r_desc;
  assign vif.valid_out_vit = r_vout;
  assign vif.normalization = r_norm;
  assign vif.sm_0_debug    = r_sm0;
endmodule

// File: tb/tb_viterbi_param.sv
// tb_viterbi_param: directed bench for viterbi_param with a trellis reference model
// and a decoded-bit scoreboard; three instances cover the default, narrow-metric and K=5 builds.
module tb_viterbi_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       sys_rst;
  logic       vit_clr;
  logic       t_valid;
  logic       t_erase;
  logic [7:0] t_soft;

  viterbi_param_if #(.SOFT_W(8), .SM_W(20)) if_a ();
  viterbi_param_if #(.SOFT_W(8), .SM_W(16)) if_b ();
  viterbi_param_if #(.SOFT_W(8), .SM_W(20)) if_c ();

  assign if_a.soft_inp = t_soft;  assign if_a.valid_in_vit = t_valid;  assign if_a.erase_in = t_erase;
  assign if_b.soft_inp = t_soft;  assign if_b.valid_in_vit = t_valid;  assign if_b.erase_in = t_erase;
  assign if_c.soft_inp = t_soft;  assign if_c.valid_in_vit = t_valid;  assign if_c.erase_in = t_erase;

  viterbi_param #(.SM_W(20)) u_a (.clk(clk), .sys_rst(sys_rst), .vit_clr(vit_clr), .vif(if_a));
  viterbi_param #(.SM_W(16)) u_b (.clk(clk), .sys_rst(sys_rst), .vit_clr(vit_clr), .vif(if_b));
  viterbi_param #(.K(5), .POLY_A('o23), .POLY_B('o35), .TB_LEN(32))
    u_c (.clk(clk), .sys_rst(sys_rst), .vit_clr(vit_clr), .vif(if_c));

  // Output view of the instance under test.
  int          sel;
  logic        m_ready, m_desc, m_valid, m_norm;
  logic [31:0] m_sm0;
  always_comb begin
    m_ready = if_a.ready_in;  m_desc = if_a.vit_desc;  m_valid = if_a.valid_out_vit;
    m_norm  = if_a.normalization;  m_sm0 = 32'(if_a.sm_0_debug);
    if (sel == 1) begin
      m_ready = if_b.ready_in;  m_desc = if_b.vit_desc;  m_valid = if_b.valid_out_vit;
      m_norm  = if_b.normalization;  m_sm0 = 32'(if_b.sm_0_debug);
    end else if (sel == 2) begin
      m_ready = if_c.ready_in;  m_desc = if_c.vit_desc;  m_valid = if_c.valid_out_vit;
      m_norm  = if_c.normalization;  m_sm0 = 32'(if_c.sm_0_debug);
    end
  end

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_strobe = 0;
  bit exp_q[$];

  // Reference model state.
  int         mk, mpa, mpb, msmw, mtb, mwarm;
  int         mpm   [64];
  logic [63:0] msurv [64];
  bit         b_phase;
  int         g1_s;
  bit         g1_e;

  bit msg [500];
  int sym [1000];
  bit er  [1000];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mpm[i]   = (i == 0) ? 0 : 1024;
      msurv[i] = '0;
    end
    mwarm   = 0;
    b_phase = 1'b0;
  endtask

  // Forward (scatter) trellis update over every source state and input bit.
  task automatic model_step(input int s1, input int s2, input bit e1, input bit e2,
                            output bit v, output bit b, output bit nrm, output int sm0);
    int          ns, w, n, m, a, g, thr;
    int          c1 [2];
    int          c2 [2];
    int          npm [64];
    logic [63:0] nsv [64];
    ns    = 1 << (mk - 1);
    thr   = 1 << (msmw - 2);
    c1[0] = e1 ? 0 : s1 + 128;  c1[1] = e1 ? 0 : 127 - s1;
    c2[0] = e2 ? 0 : s2 + 128;  c2[1] = e2 ? 0 : 127 - s2;
    for (int i = 0; i < ns; i++) begin npm[i] = 32'h7fffffff; nsv[i] = '0; end
    for (int s = 0; s < ns; s++) begin
      for (int u = 0; u < 2; u++) begin
        w = (u << (mk - 1)) | s;
        a = $countones(mpa & w) & 1;
        g = $countones(mpb & w) & 1;
        n = (u << (mk - 2)) | (s >> 1);
        m = mpm[s] + c1[a] + c2[g];
        if (m < npm[n]) begin
          npm[n] = m;
          nsv[n] = {msurv[s][62:0], u[0]};
        end
      end
    end
    nrm = 1'b1;
    for (int i = 0; i < ns; i++) if (npm[i] < thr) nrm = 1'b0;
    for (int i = 0; i < ns; i++) begin
      mpm[i]   = nrm ? npm[i] - thr : npm[i];
      msurv[i] = nsv[i];
    end
    b   = msurv[0][mtb-1];
    v   = (mwarm == mtb);
    if (mwarm < mtb) mwarm++;
    sm0 = mpm[0];
  endtask

  task automatic set_cfg(input int s, input int k, input int pa, input int pb, input int smw, input int tb);
    sel = s;  mk = k;  mpa = pa;  mpb = pb;  msmw = smw;  mtb = tb;
  endtask

  // One accepted sample; ref_bit < 0 takes the model's decision as the expected bit.
  task automatic sample(input int s, input bit e, input int ref_bit);
    bit v, b, nrm;
    int sm0;
    t_soft = 8'(s);  t_erase = e;  t_valid = 1'b1;
    if (!b_phase) begin
      g1_s = s;  g1_e = e;  b_phase = 1'b1;
      @(posedge clk); #1;
      check("g1_no_strobe", 32'(m_valid), 32'd0);
      check("g1_no_norm",   32'(m_norm),  32'd0);
      check("g1_sm0_hold",  m_sm0,        32'(mpm[0]));
    end else begin
      b_phase = 1'b0;
      model_step(g1_s, s, g1_e, e, v, b, nrm, sm0);
      if (v) exp_q.push_back((ref_bit < 0) ? b : ref_bit[0]);
      @(posedge clk); #1;
      check("step_strobe", 32'(m_valid), 32'(v));
      check("step_norm",   32'(m_norm),  32'(nrm));
      check("step_sm0",    m_sm0,        32'(sm0));
    end
    t_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    t_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check("idle_no_strobe", 32'(m_valid), 32'd0);
    end
  endtask

  // Reset or resync pulse with a competing valid sample that must be ignored.
  task automatic do_reset(input bit use_clr);
    if (use_clr) vit_clr = 1'b1; else sys_rst = 1'b1;
    t_valid = 1'b1;  t_soft = 8'sd127;  t_erase = 1'b0;
    #1 check("ready_low", 32'(m_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_desc",  32'(m_desc),  32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_norm",  32'(m_norm),  32'd0);
    check("rst_sm0",   m_sm0,        32'd0);
    sys_rst = 1'b0;  vit_clr = 1'b0;  t_valid = 1'b0;
    #1 check("ready_high", 32'(m_ready), 32'd1);
    model_reset();
  endtask

  // Encode msg[0..nbits-1], optionally flip/erase symbols, and stream it in.
  task automatic run_msg(input int nbits, input bit use_flip, input bit use_erase, input int rst_at);
    int st, w, p, rb;
    st = 0;
    for (int t = 0; t < nbits; t++) begin
      w = (int'(msg[t]) << (mk - 1)) | st;
      sym[2*t]   = ($countones(mpa & w) & 1) ? 100 : -100;
      sym[2*t+1] = ($countones(mpb & w) & 1) ? 100 : -100;
      st = w >> 1;
    end
    if (use_flip) for (int j = 0; j < 20; j++) begin
      p = 50 * j + int'($urandom_range(0, 9));
      sym[p] = -sym[p];
    end
    for (int i = 0; i < 2 * nbits; i++) begin
      er[i] = use_erase && ((i % 4) == 3);
      if (er[i]) sym[i] = int'($urandom_range(0, 255)) - 128;
    end
    for (int t = 0; t < nbits; t++) begin
      rb = (t + 1 > mtb) ? int'(msg[t + 1 - mtb]) : 0;
      sample(sym[2*t], er[2*t], rb);
      if (t + 1 == rst_at) begin
        do_reset(1'b0);
        break;
      end
      sample(sym[2*t+1], er[2*t+1], rb);
    end
  endtask

  // Scoreboard: every strobe pops one expected decoded bit.
  always @(negedge clk) begin
    if (m_valid === 1'b1) begin : mon
      bit eb;
      n_strobe++;
      if (exp_q.size() == 0) check("strobe_queue_empty", 32'(exp_q.size()), 32'd1);
      else begin
        eb = exp_q.pop_front();
        check("decoded_bit", 32'(m_desc), 32'(eb));
      end
    end
  end

  initial begin
    int base;
    sys_rst = 1'b1;  vit_clr = 1'b0;  t_valid = 1'b0;  t_soft = '0;  t_erase = 1'b0;  sel = 0;
    for (int i = 0; i < 500; i++) msg[i] = 1'($urandom_range(0, 1));
    @(posedge clk); #1;

    // All-zero codeword at full confidence.
    set_cfg(0, 7, 'o171, 'o133, 20, 64);
    do_reset(1'b0);
    base = n_strobe;
    for (int i = 0; i < 148; i++) sample(-128, 1'b0, 0);
    idle(2);
    check("zero_strobes", 32'(n_strobe - base), 32'd10);
    check("zero_sm0", m_sm0, 32'd0);
    check("zero_drained", 32'(exp_q.size()), 32'd0);

    // Random message with 20 sign-flipped symbols.
    do_reset(1'b0);
    base = n_strobe;
    run_msg(500, 1'b1, 1'b0, 0);
    idle(2);
    check("noisy_strobes", 32'(n_strobe - base), 32'd436);
    check("noisy_drained", 32'(exp_q.size()), 32'd0);

    // Narrow metrics with an uninformative stream to force renormalisation.
    set_cfg(1, 7, 'o171, 'o133, 16, 64);
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) sample(0, 1'b0, -1);
    idle(2);
    check("norm_drained", 32'(exp_q.size()), 32'd0);

    // Same message with every fourth symbol erased.
    set_cfg(0, 7, 'o171, 'o133, 20, 64);
    do_reset(1'b0);
    base = n_strobe;
    run_msg(500, 1'b0, 1'b1, 0);
    idle(2);
    check("erase_strobes", 32'(n_strobe - base), 32'd436);
    check("erase_drained", 32'(exp_q.size()), 32'd0);

    // Resync between a G1 and its G2; the held G1 must be dropped.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) sample(-128, 1'b0, 0);
    sample(127, 1'b0, 0);
    do_reset(1'b1);
    base = n_strobe;
    for (int i = 0; i < 140; i++) sample(-128, 1'b0, 0);
    idle(2);
    check("clr_strobes", 32'(n_strobe - base), 32'd6);
    check("clr_drained", 32'(exp_q.size()), 32'd0);

    // K=5 build, clean stream, reset landing on a G2.
    set_cfg(2, 5, 'o23, 'o35, 20, 32);
    do_reset(1'b0);
    base = n_strobe;
    run_msg(300, 1'b0, 1'b0, 200);
    idle(2);
    check("k5_strobes", 32'(n_strobe - base), 32'd167);
    check("k5_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
